// File: rtl/gctr_stream_if.sv
// Handshake/bus bundle for gctr_stream: command, cipher request/response,
// input block stream and output block stream.
interface gctr_stream_if #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_W      = 16
);
    logic                  start;
    logic [DATA_WIDTH-1:0] icb;
    logic [CNT_W-1:0]      num_blocks;
    logic [7:0]            last_bits;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] cb_out;
    logic [DATA_WIDTH-1:0] ciph_cb;
    logic                  ciph_valid;
    logic [DATA_WIDTH-1:0] ciph_ks;
    logic                  ciph_ks_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport slave (
        input  start, icb, num_blocks, last_bits, ciph_ks, ciph_ks_valid,
               in_data, in_valid, out_ready,
        output busy, done, cb_out, ciph_cb, ciph_valid, in_ready,
               out_data, out_valid, out_last
    );

    modport master (
        output start, icb, num_blocks, last_bits, ciph_ks, ciph_ks_valid,
               in_data, in_valid, out_ready,
        input  busy, done, cb_out, ciph_cb, ciph_valid, in_ready,
               out_data, out_valid, out_last
    );
endinterface

// File: rtl/gctr_stream.sv
// GCTR streaming engine: issues counter blocks to an external cipher, buffers
// keystream in a credit-limited FIFO and XORs it with the input block stream.
module gctr_stream #(
    parameter int DATA_WIDTH = 128,
    parameter int S          = 32,
    parameter int KS_DEPTH   = 4,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    gctr_stream_if.slave bus
);
    localparam int PW  = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int CW  = $clog2(KS_DEPTH + 1);
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cb_q, cb_d;
    logic [CNT_W-1:0]      issued_q, issued_d, paired_q, paired_d, num_q, num_d;
    logic [7:0]            last_bits_q, last_bits_d;
    logic [CW-1:0]         outst_q, outst_d, fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [KS_DEPTH];
    logic                  ciph_valid_q, ciph_valid_d;
    logic [DATA_WIDTH-1:0] ciph_cb_q, ciph_cb_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                  zero_done_q, zero_done_d;
    logic [DATA_WIDTH-1:0] cb_out_q, cb_out_d;

    logic                  issue_s, pair_s, in_ready_s, accept_last_s, final_pair_s;
    logic [CW:0]           credit_s;
    logic [8:0]            lb_s;
    logic [DATA_WIDTH-1:0] mask_s, xor_s;

    // Increment only the low S bits of a counter block, modulo 2^S.
    function automatic logic [DATA_WIDTH-1:0] inc_s(input logic [DATA_WIDTH-1:0] cb);
        logic [DATA_WIDTH-1:0] low_mask;
        low_mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - S);
        return (cb & ~low_mask) | ((cb + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) & low_mask);
    endfunction

    assign credit_s      = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign issue_s       = (state_q == RUN) && (issued_q < num_q) && (credit_s < CW1'(KS_DEPTH));
    assign in_ready_s    = (state_q == RUN) && (fifo_cnt_q != {CW{1'b0}}) && (!out_valid_q || bus.out_ready);
    assign pair_s        = bus.in_valid && in_ready_s;
    assign final_pair_s  = pair_s && ((paired_q + CNT_W'(1)) == num_q);
    assign accept_last_s = (state_q == DRAIN) && out_valid_q && bus.out_ready;
    assign lb_s          = (last_bits_q == 8'd0) ? 9'(DATA_WIDTH) : {1'b0, last_bits_q};
    // MSB-first: keep the top lb_s bits of the final block.
    assign mask_s        = ~({DATA_WIDTH{1'b1}} >> lb_s);
    assign xor_s         = bus.in_data ^ fifo_mem_q[rd_ptr_q];

    // Next-state logic for the FSM, counters, FIFO pointers and output registers.
    always_comb begin
        state_d     = state_q;
        cb_d        = cb_q;
        issued_d    = issued_q;
        paired_d    = paired_q;
        num_d       = num_q;
        last_bits_d = last_bits_q;
        outst_d     = outst_q + CW'(issue_s) - CW'(bus.ciph_ks_valid);
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ciph_valid_d = issue_s;
        ciph_cb_d   = ciph_cb_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        zero_done_d = 1'b0;
        cb_out_d    = cb_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start && (bus.num_blocks == {CNT_W{1'b0}})) begin
                    zero_done_d = 1'b1;
                    cb_out_d    = bus.icb;
                end else if (bus.start) begin
                    state_d     = RUN;
                    cb_d        = bus.icb;
                    issued_d    = {CNT_W{1'b0}};
                    paired_d    = {CNT_W{1'b0}};
                    num_d       = bus.num_blocks;
                    last_bits_d = bus.last_bits;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (final_pair_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (accept_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_s) begin
            ciph_cb_d = cb_q;
            cb_d      = inc_s(cb_q);
            issued_d  = issued_q + CNT_W'(1);
            if ((issued_q + CNT_W'(1)) == num_q) begin
                cb_out_d = inc_s(cb_q);
            end else begin
                cb_out_d = cb_out_q;
            end
        end else begin
            ciph_cb_d = ciph_cb_q;
        end

        case ({bus.ciph_ks_valid, pair_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (bus.ciph_ks_valid) begin
            wr_ptr_d = (wr_ptr_q == PW'(KS_DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pair_s) begin
            rd_ptr_d    = (rd_ptr_q == PW'(KS_DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
            paired_d    = paired_q + CNT_W'(1);
            out_valid_d = 1'b1;
            out_last_d  = final_pair_s;
            out_data_d  = final_pair_s ? (xor_s & mask_s) : xor_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cb_q         <= {DATA_WIDTH{1'b0}};
            issued_q     <= {CNT_W{1'b0}};
            paired_q     <= {CNT_W{1'b0}};
            num_q        <= {CNT_W{1'b0}};
            last_bits_q  <= 8'd0;
            outst_q      <= {CW{1'b0}};
            fifo_cnt_q   <= {CW{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            ciph_valid_q <= 1'b0;
            ciph_cb_q    <= {DATA_WIDTH{1'b0}};
            out_data_q   <= {DATA_WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            zero_done_q  <= 1'b0;
            cb_out_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            cb_q         <= cb_d;
            issued_q     <= issued_d;
            paired_q     <= paired_d;
            num_q        <= num_d;
            last_bits_q  <= last_bits_d;
            outst_q      <= outst_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ciph_valid_q <= ciph_valid_d;
            ciph_cb_q    <= ciph_cb_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            zero_done_q  <= zero_done_d;
            cb_out_q     <= cb_out_d;
        end
    end

    // Keystream storage; occupancy is tracked by the pointers and count above.
    always_ff @(posedge clk) begin
        if (bus.ciph_ks_valid) begin
            fifo_mem_q[wr_ptr_q] <= bus.ciph_ks;
        end else begin
            fifo_mem_q[wr_ptr_q] <= fifo_mem_q[wr_ptr_q];
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = zero_done_q | accept_last_s;
    assign bus.cb_out     = cb_out_q;
    assign bus.ciph_cb    = ciph_cb_q;
    assign bus.ciph_valid = ciph_valid_q;
    assign bus.in_ready   = in_ready_s;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
endmodule

// File: tb/tb_gctr_stream.sv
// Directed bench for gctr_stream with an identity cipher stub (ks = cb,
// latency 3) and a monitor that records requests, outputs and done pulses.
module tb_gctr_stream;
    localparam int DW = 128;
    localparam int SW = 32;
    localparam int KD = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic ks_zero = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gctr_stream_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

    gctr_stream #(.DATA_WIDTH(DW), .S(SW), .KS_DEPTH(KD), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Identity cipher stub, three-cycle latency.
    logic [DW-1:0] st_d [3];
    logic          st_v [3];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) st_v[i] <= 1'b0;
        end else begin
            st_v[0] <= bus.ciph_valid;
            st_d[0] <= ks_zero ? {DW{1'b0}} : bus.ciph_cb;
            st_v[1] <= st_v[0];
            st_d[1] <= st_d[0];
            st_v[2] <= st_v[1];
            st_d[2] <= st_d[1];
        end
    end
    assign bus.ciph_ks_valid = st_v[2];
    assign bus.ciph_ks       = st_d[2];

    // Monitor.
    logic [DW-1:0] req_q [$];
    logic [DW-1:0] out_q [$];
    logic          last_q [$];
    int            done_cnt, inflight, max_inflight, hold_viol;
    logic          hold_prev;
    logic [DW-1:0] held_data;
    logic          held_last;
    always @(posedge clk) begin
        if (rst || clr) begin
            req_q.delete();
            out_q.delete();
            last_q.delete();
            done_cnt     <= 0;
            inflight     <= 0;
            max_inflight <= 0;
            hold_viol    <= 0;
            hold_prev    <= 1'b0;
        end else begin
            if (bus.ciph_valid) req_q.push_back(bus.ciph_cb);
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(bus.out_data);
                last_q.push_back(bus.out_last);
            end
            if (bus.done) done_cnt <= done_cnt + 1;
            inflight <= inflight + (bus.ciph_valid ? 1 : 0) - ((bus.in_valid && bus.in_ready) ? 1 : 0);
            if (inflight > max_inflight) max_inflight <= inflight;
            if (hold_prev && ((bus.out_data !== held_data) || (bus.out_last !== held_last)))
                hold_viol <= hold_viol + 1;
            hold_prev <= bus.out_valid && !bus.out_ready;
            held_data <= bus.out_data;
            held_last <= bus.out_last;
        end
    end

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_msg(input logic [DW-1:0] icb, input logic [CW-1:0] n,
                           input logic [7:0] lb, input logic [DW-1:0] din, input int hold);
        int cyc;
        clear_mon();
        bus.icb = icb; bus.num_blocks = n; bus.last_bits = lb;
        bus.in_data = din; bus.in_valid = 1'b1; bus.start = 1'b1;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (done_cnt == 0 && cyc < 600) begin
            bus.out_ready = (cyc >= hold);
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles (required done)", cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.done, bus.ciph_valid, bus.in_ready, bus.out_valid, bus.out_last} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {bus.busy, bus.done, bus.ciph_valid, bus.in_ready, bus.out_valid, bus.out_last});
        end
        checks++;
        if (bus.cb_out !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL reset_cb_out: got %h required 0", bus.cb_out);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_v;
        run_msg(128'h1, 16'd3, 8'd0, {DW{1'b0}}, 0);
        checks++;
        if (req_q.size() !== 3 || out_q.size() !== 3) begin
            errors++;
            $display("FAIL basic_count: got req %0d out %0d required 3 3", req_q.size(), out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_v = DW'(i + 1);
                checks++;
                if (req_q[i] !== exp_v) begin
                    errors++;
                    $display("FAIL basic_req%0d: got %h required %h", i, req_q[i], exp_v);
                end
                checks++;
                if (out_q[i] !== exp_v || last_q[i] !== (i == 2)) begin
                    errors++;
                    $display("FAIL basic_out%0d: got %h last %b required %h last %b",
                             i, out_q[i], last_q[i], exp_v, (i == 2));
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done_cnt %0d busy %b required 1 0", done_cnt, bus.busy);
        end
        checks++;
        if (bus.cb_out !== 128'h4) begin
            errors++;
            $display("FAIL basic_cb_out: got %h required 4", bus.cb_out);
        end
    endtask

    task automatic test_wrap();
        run_msg(128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_FFFFFFFF, 16'd2, 8'd0, {DW{1'b0}}, 0);
        checks++;
        if (req_q.size() !== 2 || req_q[1] !== 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000000) begin
            errors++;
            $display("FAIL wrap_req: got size %0d second %h required 2 aaaaaaaaaaaaaaaaaaaaaaaa00000000",
                     req_q.size(), (req_q.size() > 1) ? req_q[1] : {DW{1'bx}});
        end
        checks++;
        if (bus.cb_out !== 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000001) begin
            errors++;
            $display("FAIL wrap_cb_out: got %h required aaaaaaaaaaaaaaaaaaaaaaaa00000001", bus.cb_out);
        end
    endtask

    task automatic test_last_bits();
        ks_zero = 1'b1;
        run_msg(128'h5, 16'd1, 8'd8, {DW{1'b1}}, 0);
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== {8'hFF, 120'h0} || last_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL last8_out: got size %0d data %h required 1 ff000000000000000000000000000000",
                     out_q.size(), (out_q.size() > 0) ? out_q[0] : {DW{1'bx}});
        end
        run_msg(128'h9, 16'd1, 8'd100, {DW{1'b1}}, 0);
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_F0000000) begin
            errors++;
            $display("FAIL last100_out: got size %0d data %h required fffffffffffffffffffffffff0000000",
                     out_q.size(), (out_q.size() > 0) ? out_q[0] : {DW{1'bx}});
        end
        ks_zero = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_v;
        run_msg(128'h100, 16'd10, 8'd0, {DW{1'b0}}, 20);
        checks++;
        if (max_inflight !== KD) begin
            errors++;
            $display("FAIL bp_inflight: got %0d required %0d", max_inflight, KD);
        end
        checks++;
        if (hold_viol !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d changes while stalled required 0", hold_viol);
        end
        checks++;
        if (out_q.size() !== 10) begin
            errors++;
            $display("FAIL bp_count: got %0d required 10", out_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                exp_v = 128'h100 + DW'(i);
                checks++;
                if (out_q[i] !== exp_v || last_q[i] !== (i == 9)) begin
                    errors++;
                    $display("FAIL bp_out%0d: got %h last %b required %h last %b",
                             i, out_q[i], last_q[i], exp_v, (i == 9));
                end
            end
        end
    endtask

    task automatic test_zero();
        clear_mon();
        bus.icb = 128'h1234_5678; bus.num_blocks = 16'd0; bus.last_bits = 8'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done %b busy %b required 1 0", bus.done, bus.busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt !== 1 || req_q.size() !== 0) begin
            errors++;
            $display("FAIL zero_once: got done_cnt %0d reqs %0d required 1 0", done_cnt, req_q.size());
        end
        checks++;
        if (bus.cb_out !== 128'h1234_5678) begin
            errors++;
            $display("FAIL zero_cb_out: got %h required 12345678", bus.cb_out);
        end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        bus.icb = 128'h50; bus.num_blocks = 16'd5; bus.last_bits = 8'd0;
        bus.in_data = {DW{1'b0}}; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.ciph_valid, bus.in_ready, bus.out_valid, bus.out_last} !== 6'b0
            || bus.cb_out !== {DW{1'b0}} || bus.out_data !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL midrst_outputs: got ctrl %b cb_out %h required all 0",
                     {bus.busy, bus.done, bus.ciph_valid, bus.in_ready, bus.out_valid, bus.out_last}, bus.cb_out);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || req_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: got done_cnt %0d reqs %0d required 0 0", done_cnt, req_q.size());
        end
        run_msg(128'h7, 16'd2, 8'd0, {DW{1'b0}}, 0);
        checks++;
        if (req_q.size() !== 2 || out_q.size() !== 2 || out_q[0] !== 128'h7 || out_q[1] !== 128'h8) begin
            errors++;
            $display("FAIL midrst_restart: got reqs %0d outs %0d required 2 2 with data 7 8",
                     req_q.size(), out_q.size());
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.icb = {DW{1'b0}}; bus.num_blocks = {CW{1'b0}}; bus.last_bits = 8'd0;
        bus.in_data = {DW{1'b0}}; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_wrap();
        test_last_bits();
        test_backpressure();
        test_zero();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gctr_stream.md
GCTR_STREAM -- requirements
Module: gctr_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 128: block width in bits; data, counter block and keystream width.
REQ-002 Parameter S, default 32: number of right-most counter-block bits incremented per block.
REQ-003 Parameter KS_DEPTH, default 4: keystream FIFO depth; also the maximum number of outstanding cipher requests.
REQ-004 Parameter CNT_W, default 16: width of the block-count field.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  command strobe; accepted only when busy=0.
REQ-008 icb  in  DATA_WIDTH  initial counter block, sampled on an accepted start.
REQ-009 num_blocks  in  CNT_W  number of blocks in the message, sampled on start.
REQ-010 last_bits  in  8  valid bits in the final block, 1..DATA_WIDTH; 0 means DATA_WIDTH; sampled on start.
REQ-011 busy  out  1  high from an accepted start until done.
REQ-012 done  out  1  one-cycle pulse when the message completes.
REQ-013 cb_out  out  DATA_WIDTH  next counter block after the last one issued; valid while busy=0.
REQ-014 ciph_cb / ciph_valid  out  DATA_WIDTH / 1  counter block request to the external block cipher.
REQ-015 ciph_ks / ciph_ks_valid  in  DATA_WIDTH / 1  cipher result; in request order, any latency, no backpressure.
REQ-016 in_data / in_valid / in_ready  in / in / out  DATA_WIDTH / 1 / 1  input blocks Xi.
REQ-017 out_data / out_valid / out_ready / out_last  out / out / in / out  DATA_WIDTH / 1 / 1 / 1  output blocks Yi.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start with num_blocks>0; RUN->DRAIN once the last block has paired; DRAIN->IDLE when the last output is accepted, with done=1 in that cycle.
REQ-019 start with num_blocks=0: no cipher request, no data accepted, done=1 on the next cycle, cb_out=icb, FSM stays IDLE.
REQ-020 Counter: first request = icb; each later request = prior with the low S bits +1 mod 2^S; upper DATA_WIDTH-S bits unchanged.
REQ-021 Request issue: ciph_valid=1 for one cycle per request, only when issued<num_blocks and outstanding+FIFO occupancy<KS_DEPTH; at most one request per cycle.
REQ-022 Each ciph_ks_valid pushes ciph_ks into the FIFO; the credit rule in REQ-021 guarantees no overflow.
REQ-023 Pairing: in_ready=1 only in RUN when the FIFO is non-empty and the output register is empty or out_ready=1.
REQ-024 Pairing on in_valid&&in_ready: pop the FIFO; register out_data = in_data XOR keystream; out_valid=1 on the next cycle (latency 1).
REQ-025 Final block: bits below the top last_bits of out_data are forced to 0 (MSB-first); out_last=1 with that block only.
REQ-026 out_data/out_last hold stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous FIFO push and pop in one cycle: occupancy unchanged.
REQ-028 cb_out updates to inc_S(last issued cb) when the final request issues.
REQ-029 start while busy=1 is ignored.

Reset
REQ-030 rst=1: FSM->IDLE; FIFO, outstanding and issued counters cleared; cb_out=0; busy, done, ciph_valid, in_ready, out_valid, out_last all 0. The external cipher shares rst, so no stale keystream returns after reset.
REQ-031 rst asserted mid-message: the message is abandoned with no done pulse; the next start after rst deasserts behaves as from power-up.

Verification
(Bench uses an identity stub cipher, ks = cb, latency 3.)
REQ-032 icb=0x...00000001, num_blocks=3, in_data=0 -> ciph_cb values ...01, ...02, ...03; out_data equals those values; out_last only on the 3rd; done once; cb_out=...04.
REQ-033 icb low 32 bits = 0xFFFFFFFF, upper bits = 0xAA..AA, num_blocks=2 -> second ciph_cb = 0xAA..AA_00000000, upper bits unchanged.
REQ-034 num_blocks=1, last_bits=8, in_data=0xFF..FF, ks=0 -> out_data=0xFF00..00 with out_last=1.
REQ-035 out_ready held low 20 cycles, num_blocks=10 -> at most KS_DEPTH requests outstanding; no FIFO overflow; outputs in order after release.
REQ-036 num_blocks=0 -> done one cycle later, ciph_valid never asserted; rst asserted mid-message -> all outputs 0 next cycle, no done.
